// File: rtl/go_timer_pkg.sv
// Shared encodings for the Go game clock: controller states, player ids and
// the length of the sec_tick blanking window after a 1 Hz restart.
package go_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic BLACK = 1'b0;
    localparam logic WHITE = 1'b1;

    localparam int RST_MASK_LEN = 3;
    localparam int MASK_W       = $clog2(RST_MASK_LEN + 1);

endpackage

// File: rtl/go_player_clock.sv
// One player's time bank: main-time seconds, byo-yomi periods and phase flag.
// expire flags the decrement that would consume the player's last second.
module go_player_clock
    import go_timer_pkg::*;
#(
    parameter int MAIN_TIME   = 600,
    parameter int BYO_TIME    = 30,
    parameter int BYO_PERIODS = 3,
    parameter int SEC_W       = 10,
    parameter int PER_W       = 2
) (
    input  logic             clk_200Hz,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic             byo_reload,
    output logic [SEC_W-1:0] secs,
    output logic [PER_W-1:0] periods,
    output logic             in_byo,
    output logic             expire
);

    localparam logic [SEC_W-1:0] SECS_MAIN = SEC_W'(MAIN_TIME);
    localparam logic [SEC_W-1:0] SECS_BYO  = SEC_W'(BYO_TIME);
    localparam logic [SEC_W-1:0] SECS_ONE  = SEC_W'(1);
    localparam logic [PER_W-1:0] PER_INIT  = PER_W'(BYO_PERIODS);
    localparam logic [PER_W-1:0] PER_ONE   = PER_W'(1);
    localparam logic             HAS_BYO   = (BYO_PERIODS > 0);

    logic last_sec;
    logic final_phase;

    // final_phase: running out of this second means the game is lost
    assign last_sec    = (secs == SECS_ONE);
    assign final_phase = in_byo ? (periods <= PER_ONE) : !HAS_BYO;
    assign expire      = dec && last_sec && final_phase;

    always_ff @(posedge clk_200Hz or negedge rst_n) begin
        if (!rst_n) begin
            secs    <= SECS_MAIN;
            periods <= PER_INIT;
            in_byo  <= 1'b0;
        end else if (load) begin
            secs    <= SECS_MAIN;
            periods <= PER_INIT;
            in_byo  <= 1'b0;
        end else if (byo_reload && in_byo) begin
            secs <= SECS_BYO;
        end else if (dec) begin
            if (secs > SECS_ONE) begin
                secs <= secs - SECS_ONE;
            end else if (last_sec) begin
                if (final_phase) begin
                    secs    <= '0;
                    periods <= '0;
                end else if (!in_byo) begin
                    in_byo <= 1'b1;
                    secs   <= SECS_BYO;
                end else begin
                    periods <= periods - PER_ONE;
                    secs    <= SECS_BYO;
                end
            end
        end
    end

endmodule

// File: rtl/go_move_timer.sv
// Go game clock controller: turn/pause/over FSM, 1 Hz tick synchroniser with
// restart blanking, and the restart pulse back to the 1 Hz generator.
module go_move_timer
    import go_timer_pkg::*;
#(
    parameter int MAIN_TIME   = 600,
    parameter int BYO_TIME    = 30,
    parameter int BYO_PERIODS = 3,
    parameter int WARN_SECS   = 10,
    parameter int SEC_W       = 10,
    parameter int PER_W       = 2
) (
    input  logic             clk_200Hz,
    input  logic             rst_n,
    input  logic             tick_1Hz,
    output logic             clk_1Hz_rst,
    input  logic             start,
    input  logic             pause,
    input  logic             move_done,
    output logic [1:0]       state,
    output logic             cur_player,
    output logic [SEC_W-1:0] black_secs,
    output logic [SEC_W-1:0] white_secs,
    output logic [PER_W-1:0] black_periods,
    output logic [PER_W-1:0] white_periods,
    output logic [1:0]       in_byoyomi,
    output logic             warn,
    output logic             timeout,
    output logic             loser
);

    state_t            st_q;
    state_t            st_d;
    logic              tick_p0;
    logic              tick_p1;
    logic              tick_p2;
    logic              tick_edge_p3;
    logic [MASK_W-1:0] mask_cnt;
    logic              sec_tick;
    logic              load;
    logic              move;
    logic              resume;
    logic              run_tick;
    logic              restart_req;
    logic              dec_b;
    logic              dec_w;
    logic              reload_b;
    logic              reload_w;
    logic              byo_b;
    logic              byo_w;
    logic              expire_b;
    logic              expire_w;
    logic              expire;
    logic [SEC_W-1:0]  run_secs;

    // synchroniser (p0, p1) then registered rising-edge detect (p3)
    always_ff @(posedge clk_200Hz or negedge rst_n) begin
        if (!rst_n) begin
            tick_p0      <= 1'b0;
            tick_p1      <= 1'b0;
            tick_p2      <= 1'b0;
            tick_edge_p3 <= 1'b0;
        end else begin
            tick_p0      <= tick_1Hz;
            tick_p1      <= tick_p0;
            tick_p2      <= tick_p1;
            tick_edge_p3 <= tick_p1 && !tick_p2;
        end
    end

    // blank ticks during the restart pulse and the window that follows it
    always_ff @(posedge clk_200Hz or negedge rst_n) begin
        if (!rst_n) begin
            mask_cnt <= '0;
        end else if (clk_1Hz_rst) begin
            mask_cnt <= MASK_W'(RST_MASK_LEN);
        end else if (mask_cnt != '0) begin
            mask_cnt <= mask_cnt - MASK_W'(1);
        end
    end

    assign sec_tick = tick_edge_p3 && !clk_1Hz_rst && (mask_cnt == '0);

    always_ff @(posedge clk_200Hz or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:  if (start) st_d = RUN;
            RUN:   if (pause) st_d = PAUSE;
                   else if (expire) st_d = OVER;
            PAUSE: if (pause) st_d = RUN;
            OVER:  if (start) st_d = RUN;
        endcase
    end

    // a move or pause in the same cycle as a tick swallows the tick
    always_comb begin
        load        = start && ((st_q == IDLE) || (st_q == OVER));
        move        = (st_q == RUN) && move_done;
        resume      = (st_q == PAUSE) && pause;
        run_tick    = (st_q == RUN) && sec_tick && !move_done && !pause;
        dec_b       = run_tick && (cur_player == BLACK);
        dec_w       = run_tick && (cur_player == WHITE);
        reload_b    = move && (cur_player == BLACK);
        reload_w    = move && (cur_player == WHITE);
        restart_req = load || move || resume;
    end

    assign expire = expire_b || expire_w;

    always_ff @(posedge clk_200Hz or negedge rst_n) begin
        if (!rst_n) begin
            cur_player  <= BLACK;
            timeout     <= 1'b0;
            loser       <= BLACK;
            clk_1Hz_rst <= 1'b0;
        end else begin
            clk_1Hz_rst <= restart_req && !clk_1Hz_rst;
            if (load) begin
                cur_player <= BLACK;
                timeout    <= 1'b0;
                loser      <= BLACK;
            end else begin
                if (move) cur_player <= !cur_player;
                if (expire) begin
                    timeout <= 1'b1;
                    loser   <= cur_player;
                end
            end
        end
    end

    go_player_clock #(
        .MAIN_TIME   (MAIN_TIME),
        .BYO_TIME    (BYO_TIME),
        .BYO_PERIODS (BYO_PERIODS),
        .SEC_W       (SEC_W),
        .PER_W       (PER_W)
    ) u_black (
        .clk_200Hz  (clk_200Hz),
        .rst_n      (rst_n),
        .load       (load),
        .dec        (dec_b),
        .byo_reload (reload_b),
        .secs       (black_secs),
        .periods    (black_periods),
        .in_byo     (byo_b),
        .expire     (expire_b)
    );

    go_player_clock #(
        .MAIN_TIME   (MAIN_TIME),
        .BYO_TIME    (BYO_TIME),
        .BYO_PERIODS (BYO_PERIODS),
        .SEC_W       (SEC_W),
        .PER_W       (PER_W)
    ) u_white (
        .clk_200Hz  (clk_200Hz),
        .rst_n      (rst_n),
        .load       (load),
        .dec        (dec_w),
        .byo_reload (reload_w),
        .secs       (white_secs),
        .periods    (white_periods),
        .in_byo     (byo_w),
        .expire     (expire_w)
    );

    assign run_secs   = cur_player ? white_secs : black_secs;
    assign warn       = (st_q == RUN) && (run_secs <= SEC_W'(WARN_SECS));
    assign state      = st_q;
    assign in_byoyomi = {byo_w, byo_b};

endmodule

// File: tb/tb_go_move_timer.sv
// Bench for go_move_timer: game-rule model checked every cycle, directed
// scenarios with literal expectations, then randomized play.
module tb_go_move_timer;

    localparam int MT = 3;
    localparam int BT = 2;
    localparam int BP = 2;
    localparam int WS = 1;
    localparam int SW = 10;
    localparam int PW = 2;

    logic          clk_200Hz = 1'b0;
    logic          rst_n     = 1'b0;
    logic          tick_1Hz  = 1'b0;
    logic          start     = 1'b0;
    logic          pause     = 1'b0;
    logic          move_done = 1'b0;
    logic          clk_1Hz_rst;
    logic [1:0]    state;
    logic          cur_player;
    logic [SW-1:0] black_secs;
    logic [SW-1:0] white_secs;
    logic [PW-1:0] black_periods;
    logic [PW-1:0] white_periods;
    logic [1:0]    in_byoyomi;
    logic          warn;
    logic          timeout;
    logic          loser;

    int n_cmp   = 0;
    int n_bad   = 0;
    int gen_cnt = 150;

    go_move_timer #(
        .MAIN_TIME(MT), .BYO_TIME(BT), .BYO_PERIODS(BP),
        .WARN_SECS(WS), .SEC_W(SW), .PER_W(PW)
    ) dut (
        .clk_200Hz     (clk_200Hz),
        .rst_n         (rst_n),
        .tick_1Hz      (tick_1Hz),
        .clk_1Hz_rst   (clk_1Hz_rst),
        .start         (start),
        .pause         (pause),
        .move_done     (move_done),
        .state         (state),
        .cur_player    (cur_player),
        .black_secs    (black_secs),
        .white_secs    (white_secs),
        .black_periods (black_periods),
        .white_periods (white_periods),
        .in_byoyomi    (in_byoyomi),
        .warn          (warn),
        .timeout       (timeout),
        .loser         (loser)
    );

    always #5 clk_200Hz = ~clk_200Hz;

    // 1 Hz generator: 200-cycle second, high in the first half, restartable
    initial begin
        forever begin
            @(negedge clk_200Hz);
            if (clk_1Hz_rst) gen_cnt = 0;
            else gen_cnt = (gen_cnt + 1) % 200;
            tick_1Hz = (gen_cnt < 100);
        end
    end

    // game model: st 0..3, secs/periods/byo per player, tick/pulse history
    typedef struct packed {
        logic [1:0] st;
        logic       cur;
        logic [7:0] sb, sw, pb, pw;
        logic       yb, yw, tout, los, pulse;
        logic [3:0] xh;
        logic [3:0] ph;
    } m_t;

    m_t m;

    function automatic m_t m_reset();
        m_t r;
        r.st = 2'd0; r.cur = 1'b0;
        r.sb = 8'(MT); r.sw = 8'(MT); r.pb = 8'(BP); r.pw = 8'(BP);
        r.yb = 1'b0; r.yw = 1'b0; r.tout = 1'b0; r.los = 1'b0; r.pulse = 1'b0;
        r.xh = 4'b0; r.ph = 4'b0;
        return r;
    endfunction

    function automatic m_t step(input m_t mi, input logic t_in, input logic s_in,
                                input logic p_in, input logic mv_in);
        m_t   n;
        int   s[2];
        int   p[2];
        logic y[2];
        int   c;
        logic tick;
        logic want;
        n = mi;
        s[0] = int'(mi.sb); s[1] = int'(mi.sw);
        p[0] = int'(mi.pb); p[1] = int'(mi.pw);
        y[0] = mi.yb;       y[1] = mi.yw;
        // a second is seen 3 cycles after the input rises, unless a restart is recent
        tick = mi.xh[2] && !mi.xh[3] && (mi.ph == 4'b0);
        want = 1'b0;
        c = int'(mi.cur);
        case (mi.st)
            2'd0: if (s_in) begin n.st = 2'd1; n.cur = 1'b0; want = 1'b1; end
            2'd1: begin
                if (mv_in) begin
                    if (y[c]) s[c] = BT;
                    n.cur = !mi.cur;
                    want = 1'b1;
                    if (p_in) n.st = 2'd2;
                end else if (p_in) begin
                    n.st = 2'd2;
                end else if (tick) begin
                    if (s[c] > 1) s[c] = s[c] - 1;
                    else if (s[c] == 1) begin
                        if (!y[c] && BP > 0) begin y[c] = 1'b1; s[c] = BT; end
                        else if (y[c] && p[c] > 1) begin p[c] = p[c] - 1; s[c] = BT; end
                        else begin
                            s[c] = 0; p[c] = 0;
                            n.tout = 1'b1; n.los = mi.cur; n.st = 2'd3;
                        end
                    end
                end
            end
            2'd2: if (p_in) begin n.st = 2'd1; want = 1'b1; end
            default: if (s_in) begin
                s[0] = MT; s[1] = MT; p[0] = BP; p[1] = BP;
                y[0] = 1'b0; y[1] = 1'b0;
                n.tout = 1'b0; n.los = 1'b0; n.cur = 1'b0; n.st = 2'd1;
                want = 1'b1;
            end
        endcase
        n.sb = 8'(s[0]); n.sw = 8'(s[1]); n.pb = 8'(p[0]); n.pw = 8'(p[1]);
        n.yb = y[0]; n.yw = y[1];
        n.pulse = want && !mi.pulse;
        n.xh = {mi.xh[2:0], t_in};
        n.ph = {mi.ph[2:0], n.pulse};
        return n;
    endfunction

    always @(posedge clk_200Hz or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else m <= step(m, tick_1Hz, start, pause, move_done);
    end

    logic exp_warn;
    assign exp_warn = (m.st == 2'd1) && ((m.cur ? m.sw : m.sb) <= 8'(WS));

    always @(posedge clk_200Hz) begin
        #1;
        n_cmp++;
        if (state !== m.st || cur_player !== m.cur ||
            black_secs !== SW'(m.sb) || white_secs !== SW'(m.sb ^ m.sb ^ m.sw) ||
            black_periods !== PW'(m.pb) || white_periods !== PW'(m.pw) ||
            in_byoyomi !== {m.yw, m.yb} || warn !== exp_warn ||
            timeout !== m.tout || loser !== m.los || clk_1Hz_rst !== m.pulse) begin
            n_bad++;
            $display("FAIL cycle t=%0t dut st=%0d cur=%0d b=%0d/%0d w=%0d/%0d byo=%b warn=%b to=%b los=%b rst1=%b | model st=%0d cur=%0d b=%0d/%0d w=%0d/%0d byo=%b warn=%b to=%b los=%b rst1=%b",
                     $time, state, cur_player, black_secs, black_periods, white_secs, white_periods,
                     in_byoyomi, warn, timeout, loser, clk_1Hz_rst,
                     m.st, m.cur, m.sb, m.pb, m.sw, m.pw, {m.yw, m.yb}, exp_warn, m.tout, m.los, m.pulse);
        end
    end

    function automatic int get(input int sel);
        case (sel)
            0: return int'(black_secs);
            1: return int'(white_secs);
            2: return int'(black_periods);
            3: return int'(white_periods);
            4: return int'(state);
            5: return int'(in_byoyomi);
            6: return int'(cur_player);
            default: return int'(timeout);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_for(input string name, input int sel, input int val, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk_200Hz);
            if (get(sel) == val) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d within %0d cycles", name, get(sel), val, budget);
        end
    endtask

    task automatic pulse_in(input int which);
        @(negedge clk_200Hz);
        case (which)
            0: start = 1'b1;
            1: pause = 1'b1;
            default: move_done = 1'b1;
        endcase
        @(negedge clk_200Hz);
        start = 1'b0; pause = 1'b0; move_done = 1'b0;
    endtask

    initial begin
        int bs, ws, bpv, wpv, cp, rate;
        bit found;
        repeat (3) @(negedge clk_200Hz);
        rst_n = 1'b1;
        chk("rst_state", int'(state), 0);
        chk("rst_black_secs", int'(black_secs), 3);
        chk("rst_white_secs", int'(white_secs), 3);
        chk("rst_black_periods", int'(black_periods), 2);
        chk("rst_clk_1Hz_rst", int'(clk_1Hz_rst), 0);
        repeat (5) @(negedge clk_200Hz);

        // start and black's main time
        pulse_in(0);
        chk("start_state", int'(state), 1);
        chk("start_cur", int'(cur_player), 0);
        chk("start_pulse", int'(clk_1Hz_rst), 1);
        @(negedge clk_200Hz);
        chk("pulse_one_cycle", int'(clk_1Hz_rst), 0);
        wait_for("black_3to2", 0, 2, 260);
        chk("white_holds", int'(white_secs), 3);
        wait_for("black_2to1", 0, 1, 260);
        chk("warn_at_1", int'(warn), 1);

        // black runs out through byo-yomi
        wait_for("enter_byo", 5, 1, 260);
        chk("byo_secs", int'(black_secs), 2);
        chk("byo_periods", int'(black_periods), 2);
        wait_for("period_used", 2, 1, 460);
        chk("period_reload", int'(black_secs), 2);
        wait_for("over", 4, 3, 460);
        chk("timeout", int'(timeout), 1);
        chk("loser_black", int'(loser), 0);
        chk("over_black_secs", int'(black_secs), 0);
        chk("over_black_periods", int'(black_periods), 0);
        chk("over_white_secs", int'(white_secs), 3);

        // restart from OVER
        pulse_in(0);
        chk("restart_state", int'(state), 1);
        chk("restart_secs", int'(black_secs), 3);
        chk("restart_periods", int'(black_periods), 2);
        chk("restart_byo", int'(in_byoyomi), 0);
        chk("restart_timeout", int'(timeout), 0);

        // move in byo-yomi reloads the mover
        wait_for("byo_again", 5, 1, 800);
        wait_for("byo_secs_1", 0, 1, 260);
        pulse_in(2);
        chk("move_reload", int'(black_secs), 2);
        chk("move_periods", int'(black_periods), 2);
        chk("move_cur", int'(cur_player), 1);
        chk("move_pulse", int'(clk_1Hz_rst), 1);
        wait_for("white_runs", 1, 2, 260);
        chk("black_frozen", int'(black_secs), 2);

        // move lands in the same cycle as sec_tick
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk_200Hz);
            if (gen_cnt == 0) found = 1'b1;
        end
        chk("tick_found", int'(found), 1);
        @(negedge clk_200Hz);
        @(negedge clk_200Hz);
        @(negedge clk_200Hz);
        bs = int'(black_secs); ws = int'(white_secs); cp = int'(cur_player);
        move_done = 1'b1;
        @(negedge clk_200Hz);
        move_done = 1'b0;
        chk("collide_black", int'(black_secs), bs);
        chk("collide_white", int'(white_secs), ws);
        chk("collide_cur", int'(cur_player), 1 - cp);

        // pause freezes everything
        repeat (5) @(negedge clk_200Hz);
        bs = int'(black_secs); ws = int'(white_secs);
        bpv = int'(black_periods); wpv = int'(white_periods);
        pulse_in(1);
        chk("pause_state", int'(state), 2);
        repeat (1000) @(negedge clk_200Hz);
        chk("pause_state_held", int'(state), 2);
        chk("pause_black", int'(black_secs), bs);
        chk("pause_white", int'(white_secs), ws);
        chk("pause_bper", int'(black_periods), bpv);
        chk("pause_wper", int'(white_periods), wpv);
        pulse_in(1);
        chk("resume_state", int'(state), 1);
        chk("resume_pulse", int'(clk_1Hz_rst), 1);
        wait_for("resume_dec", 0, bs - 1, 260);

        // asynchronous reset mid-RUN
        @(negedge clk_200Hz);
        rst_n = 1'b0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_black", int'(black_secs), 3);
        chk("arst_white", int'(white_secs), 3);
        chk("arst_wper", int'(white_periods), 2);
        chk("arst_byo", int'(in_byoyomi), 0);
        chk("arst_cur", int'(cur_player), 0);
        @(negedge clk_200Hz);
        rst_n = 1'b1;

        // randomized play against the model
        pulse_in(0);
        rate = 300;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_200Hz);
            if (i % 2000 == 0) rate = int'($urandom_range(100, 600));
            start     = ($urandom_range(0, 1499) == 0);
            pause     = ($urandom_range(0, 699) == 0);
            move_done = ($urandom_range(0, rate - 1) == 0);
        end
        @(negedge clk_200Hz);
        start = 1'b0; pause = 1'b0; move_done = 1'b0;
        repeat (5) @(negedge clk_200Hz);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
